// File: rtl/rprelu_para_loader_if.sv
// Parameter word stream into the RPReLU table loader: data, valid, ready.
// Master is the parameter-bus side, slave is the loader.
`ifndef PARA_WIDTH
`define PARA_WIDTH 16
`endif
`ifndef CALCULATE
`define CALCULATE 1'b1
`endif

interface rprelu_para_loader_if;
    logic signed [`PARA_WIDTH-1:0] para_in;
    logic                          para_valid;
    logic                          para_ready;

    modport master (
        output para_in,
        output para_valid,
        input  para_ready
    );

    modport slave (
        input  para_in,
        input  para_valid,
        output para_ready
    );
endinterface

// File: rtl/rprelu_para_loader.sv
// RPReLU beta/gamma/zeta table loader; RPRELU_PARA_CHECKSUM_EN adds a trailing checksum word.
// Latency: accepted word lands in its table one edge later; load_done one edge after the last word.
// Backpressure: para_ready is high for the whole load (no stalls inside a table), low otherwise.
`ifndef PARA_WIDTH
`define PARA_WIDTH 16
`endif
`ifndef CALCULATE
`define CALCULATE 1'b1
`endif

module rprelu_para_loader #(
    parameter int CHANNEL_NUM = 512,
    parameter int CNT_WIDTH   = 9
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          mode_i,
    input  logic                          load_start_i,
    rprelu_para_loader_if.slave           para_if,
    output logic signed [`PARA_WIDTH-1:0] rprelu_beta_o  [CHANNEL_NUM],
    output logic signed [`PARA_WIDTH-1:0] rprelu_gamma_o [CHANNEL_NUM],
    output logic signed [`PARA_WIDTH-1:0] rprelu_zeta_o  [CHANNEL_NUM],
    output logic                          load_done_o,
    output logic                          load_abort_o
`ifdef RPRELU_PARA_CHECKSUM_EN
    ,
    output logic                          chk_err_o
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        LD_BETA,
        LD_GAMMA,
        LD_ZETA,
`ifdef RPRELU_PARA_CHECKSUM_EN
        LD_CHK,
`endif
        DONE
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(CHANNEL_NUM - 1);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] cnt_nxt;
    logic                 done_q, done_d;
    logic                 abort_q, abort_d;
    logic                 calc;
    logic                 in_ld;
    logic                 ready;
    logic                 accept;
    logic                 start;
    logic                 last;
    logic                 wr_beta, wr_gamma, wr_zeta;

    assign calc   = (mode_i == `CALCULATE);
`ifdef RPRELU_PARA_CHECKSUM_EN
    assign in_ld  = (state_q inside {LD_BETA, LD_GAMMA, LD_ZETA, LD_CHK});
`else
    assign in_ld  = (state_q inside {LD_BETA, LD_GAMMA, LD_ZETA});
`endif
    assign ready  = in_ld && !calc;
    assign accept = para_if.para_valid && ready;
    assign start  = load_start_i && !calc;
    assign last   = (cnt_q == CNT_LAST);
    assign cnt_nxt = last ? '0 : cnt_q + 1'b1;

    assign para_if.para_ready = ready;
    assign load_done_o        = done_q;
    assign load_abort_o       = abort_q;

`ifdef RPRELU_PARA_CHECKSUM_EN
    logic [`PARA_WIDTH-1:0] sum_q, sum_d;
    logic                   chk_err_q, chk_err_d;
    logic                   chk_match;

    assign chk_match = (para_if.para_in == sum_q);
    assign chk_err_o = chk_err_q;

    // Only table words feed the sum; the checksum word itself is excluded.
    always_comb begin
        sum_d = sum_q;
        if (start) begin
            sum_d = '0;
        end else if (accept && (state_q inside {LD_BETA, LD_GAMMA, LD_ZETA})) begin
            sum_d = sum_q + para_if.para_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q     <= '0;
            chk_err_q <= 1'b0;
        end else begin
            sum_q     <= sum_d;
            chk_err_q <= chk_err_d;
        end
    end
`endif

    // Restart beats abort beats word acceptance; a word offered alongside a
    // restart pulse is dropped.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = done_q;
        abort_d  = 1'b0;
        wr_beta  = 1'b0;
        wr_gamma = 1'b0;
        wr_zeta  = 1'b0;
`ifdef RPRELU_PARA_CHECKSUM_EN
        chk_err_d = chk_err_q;
`endif
        if (start) begin
            state_d = LD_BETA;
            cnt_d   = '0;
            done_d  = 1'b0;
`ifdef RPRELU_PARA_CHECKSUM_EN
            chk_err_d = 1'b0;
`endif
        end else if (in_ld && calc) begin
            state_d = IDLE;
            cnt_d   = '0;
            abort_d = 1'b1;
        end else if (accept) begin
            case (state_q)
                LD_BETA: begin
                    wr_beta = 1'b1;
                    cnt_d   = cnt_nxt;
                    if (last) state_d = LD_GAMMA;
                end
                LD_GAMMA: begin
                    wr_gamma = 1'b1;
                    cnt_d    = cnt_nxt;
                    if (last) state_d = LD_ZETA;
                end
                LD_ZETA: begin
                    wr_zeta = 1'b1;
                    cnt_d   = cnt_nxt;
                    if (last) begin
`ifdef RPRELU_PARA_CHECKSUM_EN
                        state_d = LD_CHK;
`else
                        state_d = DONE;
                        done_d  = 1'b1;
`endif
                    end
                end
`ifdef RPRELU_PARA_CHECKSUM_EN
                LD_CHK: begin
                    if (chk_match) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = IDLE;
                        chk_err_d = 1'b1;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNEL_NUM; i++) begin
                rprelu_beta_o[i]  <= '0;
                rprelu_gamma_o[i] <= '0;
                rprelu_zeta_o[i]  <= '0;
            end
        end else begin
            if (wr_beta)  rprelu_beta_o[cnt_q]  <= para_if.para_in;
            if (wr_gamma) rprelu_gamma_o[cnt_q] <= para_if.para_in;
            if (wr_zeta)  rprelu_zeta_o[cnt_q]  <= para_if.para_in;
        end
    end

endmodule
